// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter for the IF and MEM pipeline stages.
// Data accesses win over fetches; freeze outputs hold the pipeline while an access is in flight.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_rd_en,
    input  logic              dm_wr_en,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              sram_req,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_ready,
    output logic              freeze_if,
    output logic              freeze_mem,
    output logic [15:0]       stall_cycles
);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        INSTR,
        D_DONE,
        I_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                sram_req_q, sram_req_d;
    logic                sram_we_q, sram_we_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]   sram_wdata_q, sram_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                if_done_q, if_done_d;
    logic                dm_done_q, dm_done_d;
    logic [15:0]         stall_q, stall_d;
    logic                dm_req;

    assign dm_req     = dm_rd_en | dm_wr_en;
    assign freeze_mem = dm_req & (state_q != D_DONE);
    assign freeze_if  = freeze_mem | (if_req & (state_q != I_DONE));

    always_comb begin
        state_d      = state_q;
        sram_req_d   = sram_req_q;
        sram_we_d    = sram_we_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if_done_d    = 1'b0;
        dm_done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (dm_req) begin
                    sram_addr_d  = dm_addr;
                    sram_wdata_d = dm_wdata;
                    sram_we_d    = dm_wr_en;
                    sram_req_d   = 1'b1;
                    state_d      = DATA;
                end else if (if_req) begin
                    sram_addr_d = if_addr;
                    sram_we_d   = 1'b0;
                    sram_req_d  = 1'b1;
                    state_d     = INSTR;
                end
            end
            // Accesses run to completion even if the requester has dropped its request.
            DATA: begin
                if (sram_ready) begin
                    if (!sram_we_q) begin
                        dm_rdata_d = sram_rdata;
                    end
                    sram_req_d = 1'b0;
                    dm_done_d  = 1'b1;
                    state_d    = D_DONE;
                end
            end
            INSTR: begin
                if (sram_ready) begin
                    if_rdata_d = sram_rdata;
                    sram_req_d = 1'b0;
                    if_done_d  = 1'b1;
                    state_d    = I_DONE;
                end
            end
            D_DONE:  state_d = IDLE;
            I_DONE:  state_d = IDLE;
            default: begin
                state_d    = IDLE;
                sram_req_d = 1'b0;
            end
        endcase

        stall_d = stall_q;
        if (freeze_if && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sram_req_q   <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            if_done_q    <= 1'b0;
            dm_done_q    <= 1'b0;
            stall_q      <= 16'd0;
        end else begin
            state_q      <= state_d;
            sram_req_q   <= sram_req_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            if_done_q    <= if_done_d;
            dm_done_q    <= dm_done_d;
            stall_q      <= stall_d;
        end
    end

    assign sram_req     = sram_req_q;
    assign sram_we      = sram_we_q;
    assign sram_addr    = sram_addr_q;
    assign sram_wdata   = sram_wdata_q;
    assign if_rdata     = if_rdata_q;
    assign dm_rdata     = dm_rdata_q;
    assign if_done      = if_done_q;
    assign dm_done      = dm_done_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed cycle checks plus a scoreboard of
// expected SRAM accesses and completion data, popped as the DUT produces them.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_rd_en;
    logic        dm_wr_en;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        sram_req;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ready;
    logic        freeze_if;
    logic        freeze_mem;
    logic [15:0] stall_cycles;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } sram_exp_t;

    sram_exp_t   sram_q[$];
    logic [31:0] dm_q[$];
    logic [31:0] if_q[$];

    int compareCount = 0;
    int failCount    = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_done      (if_done),
        .dm_rd_en     (dm_rd_en),
        .dm_wr_en     (dm_wr_en),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata),
        .dm_done      (dm_done),
        .sram_req     (sram_req),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready),
        .freeze_if    (freeze_if),
        .freeze_mem   (freeze_mem),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Starts a new cycle just after the rising edge and drives every request input.
    task automatic applyStimulus(input logic ifr, input logic [31:0] ia, input logic rd, input logic wr,
                                 input logic [31:0] da, input logic [31:0] wd,
                                 input logic rdy, input logic [31:0] rdat);
        @(posedge clk);
        #1;
        if_req     = ifr;
        if_addr    = ia;
        dm_rd_en   = rd;
        dm_wr_en   = wr;
        dm_addr    = da;
        dm_wdata   = wd;
        sram_ready = rdy;
        sram_rdata = rdat;
        #1;
    endtask

    task automatic pushSram(input logic [31:0] a, input logic w, input logic [31:0] d);
        sram_exp_t e;
        e.addr  = a;
        e.we    = w;
        e.wdata = d;
        sram_q.push_back(e);
    endtask

    // Scoreboard monitor: completed SRAM handshakes and done pulses consume queued expectations.
    always @(negedge clk) begin
        if (!rst) begin
            if (sram_req && sram_ready) begin
                if (sram_q.size() == 0) begin
                    checkOutput("unexpected_sram_access", sram_addr, 32'hFFFF_FFFF);
                end else begin
                    sram_exp_t e;
                    e = sram_q.pop_front();
                    checkOutput("sb_sram_addr", sram_addr, e.addr);
                    checkOutput("sb_sram_we", {31'd0, sram_we}, {31'd0, e.we});
                    if (e.we) checkOutput("sb_sram_wdata", sram_wdata, e.wdata);
                end
            end
            if (dm_done) begin
                if (dm_q.size() == 0) checkOutput("unexpected_dm_done", 32'd1, 32'd0);
                else checkOutput("sb_dm_rdata", dm_rdata, dm_q.pop_front());
            end
            if (if_done) begin
                if (if_q.size() == 0) checkOutput("unexpected_if_done", 32'd1, 32'd0);
                else checkOutput("sb_if_rdata", if_rdata, if_q.pop_front());
            end
        end
    end

    initial begin
        rst        = 1'b1;
        if_req     = 1'b0;
        if_addr    = '0;
        dm_rd_en   = 1'b0;
        dm_wr_en   = 1'b0;
        dm_addr    = '0;
        dm_wdata   = '0;
        sram_ready = 1'b0;
        sram_rdata = '0;
        #12;
        checkOutput("rst_sram_req", {31'd0, sram_req}, 32'd0);
        checkOutput("rst_sram_we", {31'd0, sram_we}, 32'd0);
        checkOutput("rst_sram_addr", sram_addr, 32'd0);
        checkOutput("rst_sram_wdata", sram_wdata, 32'd0);
        checkOutput("rst_if_rdata", if_rdata, 32'd0);
        checkOutput("rst_dm_rdata", dm_rdata, 32'd0);
        checkOutput("rst_done", {30'd0, if_done, dm_done}, 32'd0);
        checkOutput("rst_stall", {16'd0, stall_cycles}, 32'd0);
        checkOutput("rst_freeze", {30'd0, freeze_if, freeze_mem}, 32'd0);
        rst = 1'b0;

        $display("[TB] single load, immediate ready");
        pushSram(32'h40, 1'b0, 32'h0);
        dm_q.push_back(32'hDEADBEEF);
        applyStimulus(0, 0, 1, 0, 32'h40, 0, 0, 0);
        checkOutput("ld_c0_freeze_mem", {31'd0, freeze_mem}, 32'd1);
        checkOutput("ld_c0_sram_req", {31'd0, sram_req}, 32'd0);
        applyStimulus(0, 0, 1, 0, 32'h40, 0, 1, 32'hDEADBEEF);
        checkOutput("ld_c1_sram_req", {31'd0, sram_req}, 32'd1);
        checkOutput("ld_c1_freeze_mem", {31'd0, freeze_mem}, 32'd1);
        applyStimulus(0, 0, 1, 0, 32'h40, 0, 0, 0);
        checkOutput("ld_c2_dm_done", {31'd0, dm_done}, 32'd1);
        checkOutput("ld_c2_dm_rdata", dm_rdata, 32'hDEADBEEF);
        checkOutput("ld_c2_freeze", {30'd0, freeze_if, freeze_mem}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("ld_c3_dm_done", {31'd0, dm_done}, 32'd0);
        checkOutput("ld_c3_stall", {16'd0, stall_cycles}, 32'd2);

        $display("[TB] store with three wait states");
        pushSram(32'h80, 1'b1, 32'h1234);
        dm_q.push_back(32'hDEADBEEF);
        applyStimulus(0, 0, 0, 1, 32'h80, 32'h1234, 0, 0);
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(0, 0, 0, 1, 32'h80, 32'h1234, (c == 4), 32'h5555_5555);
            checkOutput($sformatf("st_c%0d_sram", c), {29'd0, sram_req, sram_we, freeze_mem}, 32'd7);
            checkOutput($sformatf("st_c%0d_addr", c), sram_addr, 32'h80);
            checkOutput($sformatf("st_c%0d_wdata", c), sram_wdata, 32'h1234);
        end
        applyStimulus(0, 0, 0, 1, 32'h80, 32'h1234, 0, 0);
        checkOutput("st_c5_dm_done", {31'd0, dm_done}, 32'd1);
        checkOutput("st_c5_dm_rdata", dm_rdata, 32'hDEADBEEF);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] simultaneous fetch and load");
        pushSram(32'h100, 1'b0, 32'h0);
        pushSram(32'h0, 1'b0, 32'h0);
        dm_q.push_back(32'hAAAA0001);
        if_q.push_back(32'hE3A00001);
        applyStimulus(1, 32'h0, 1, 0, 32'h100, 0, 0, 0);
        checkOutput("sim_c0_freeze", {30'd0, freeze_if, freeze_mem}, 32'd3);
        applyStimulus(1, 32'h0, 1, 0, 32'h100, 0, 1, 32'hAAAA0001);
        checkOutput("sim_c1_addr", sram_addr, 32'h100);
        applyStimulus(1, 32'h0, 1, 0, 32'h100, 0, 0, 0);
        checkOutput("sim_c2_dm_done", {31'd0, dm_done}, 32'd1);
        checkOutput("sim_c2_freeze", {30'd0, freeze_if, freeze_mem}, 32'd2);
        applyStimulus(1, 32'h0, 0, 0, 0, 0, 0, 0);
        checkOutput("sim_c3_req_freeze", {30'd0, sram_req, freeze_if}, 32'd1);
        applyStimulus(1, 32'h0, 0, 0, 0, 0, 1, 32'hE3A00001);
        checkOutput("sim_c4_req_freeze", {30'd0, sram_req, freeze_if}, 32'd3);
        checkOutput("sim_c4_addr", sram_addr, 32'h0);
        applyStimulus(1, 32'h0, 0, 0, 0, 0, 0, 0);
        checkOutput("sim_c5_if_done", {31'd0, if_done}, 32'd1);
        checkOutput("sim_c5_freeze_if", {31'd0, freeze_if}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] fetch flushed mid-access");
        pushSram(32'h200, 1'b0, 32'h0);
        if_q.push_back(32'h0000600D);
        applyStimulus(1, 32'h200, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fl_c1_req_freeze", {30'd0, sram_req, freeze_if}, 32'd2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fl_c2_sram_req", {31'd0, sram_req}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0000600D);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fl_c4_if_done", {31'd0, if_done}, 32'd1);
        checkOutput("fl_c4_if_rdata", if_rdata, 32'h0000600D);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fl_c5_if_done", {31'd0, if_done}, 32'd0);

        $display("[TB] reset during an access");
        applyStimulus(0, 0, 1, 0, 32'h300, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 32'h300, 0, 0, 0);
        checkOutput("rm_c1_sram_req", {31'd0, sram_req}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rm_req_done", {29'd0, sram_req, dm_done, if_done}, 32'd0);
        checkOutput("rm_stall", {16'd0, stall_cycles}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hBAD0BAD0);
            checkOutput($sformatf("rm_post%0d", c), {29'd0, sram_req, dm_done, if_done}, 32'd0);
        end

        $display("[TB] stall counter saturation");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("sat_start", {16'd0, stall_cycles}, 32'd0);
        applyStimulus(1, 32'h400, 0, 0, 0, 0, 0, 0);
        repeat (65534) @(posedge clk);
        #1;
        checkOutput("sat_fffe", {16'd0, stall_cycles}, 32'h0000FFFE);
        @(posedge clk);
        #1;
        checkOutput("sat_ffff", {16'd0, stall_cycles}, 32'h0000FFFF);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("sat_hold", {16'd0, stall_cycles}, 32'h0000FFFF);
        rst = 1'b1;
        if_req = 1'b0;
        #1;
        rst = 1'b0;

        checkOutput("sb_sram_left", sram_q.size(), 32'd0);
        checkOutput("sb_dm_left", dm_q.size(), 32'd0);
        checkOutput("sb_if_left", if_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
